// File: rtl/product_accumulator.sv
// product_accumulator: saturating multiply-accumulate back-end for the Booth
// multiplier. Sums signed 2N-bit products into a guard-extended accumulator
// and presents one result per frame over a valid/ready handshake.
module product_accumulator #(
   parameter int N  = 32,
   parameter int G  = 8,
   parameter int CW = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2*N-1:0]    in_product,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*N+G-1:0]  out_sum,
   output logic [CW-1:0]     out_count,
   output logic              out_ovf
);
   localparam int AW = 2*N + G;

   typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

   state_t        state;
   logic [AW-1:0] acc;
   logic [AW-1:0] acc_nxt;
   logic [CW-1:0] count;
   logic [CW-1:0] cnt_nxt;
   logic          ovf;
   logic          rdy;
   logic          sat;
   logic [AW:0]   wide;
   logic          accept;

   // in_ready comes straight from a flop so out_ready never reaches it
   assign in_ready = rdy;
   assign accept   = in_valid & rdy;

   // One-bit-wider add exposes signed overflow; clamp to the AW-bit range
   always_comb begin
      wide    = {acc[AW-1], acc} + {{(G+1){in_product[2*N-1]}}, in_product};
      sat     = wide[AW] ^ wide[AW-1];
      acc_nxt = wide[AW-1:0];
      if (sat)
         acc_nxt = wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      cnt_nxt = (&count) ? count : count + CW'(1);
   end

   // Frame FSM: accumulate in ACC, present and hold the result in HOLD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACC;
         rdy       <= 1'b0;
         acc       <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else if (clear) begin
         // flush wins over any beat or handshake in the same cycle
         state     <= ACC;
         rdy       <= 1'b1;
         acc       <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ACC: begin
               rdy <= 1'b1;
               if (accept) begin
                  acc   <= acc_nxt;
                  count <= cnt_nxt;
                  ovf   <= ovf | sat;
                  if (in_last) begin
                     out_sum   <= acc_nxt;
                     out_count <= cnt_nxt;
                     out_ovf   <= ovf | sat;
                     out_valid <= 1'b1;
                     rdy       <= 1'b0;
                     state     <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  acc       <= '0;
                  count     <= '0;
                  ovf       <= 1'b0;
                  out_valid <= 1'b0;
                  rdy       <= 1'b1;
                  state     <= ACC;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a default-size instance for directed
// sequences and a narrow instance (AW=9, CW=8) for saturation and random runs.
module tb_product_accumulator;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // wide instance: N=32, G=8, CW=16
   logic        clear0 = 1'b0, iv0 = 1'b0, last0 = 1'b0, ordy0 = 1'b0;
   logic [63:0] prod0 = '0;
   logic        ir0, ov0, ovf0;
   logic [71:0] sum0;
   logic [15:0] cnt0;

   // narrow instance: N=4, G=1, CW=8
   logic        clear1 = 1'b0, iv1 = 1'b0, last1 = 1'b0, ordy1 = 1'b0;
   logic [7:0]  prod1 = '0;
   logic        ir1, ov1, ovf1;
   logic [8:0]  sum1;
   logic [7:0]  cnt1;

   product_accumulator #(.N(32), .G(8), .CW(16)) d0 (
      .clk(clk), .rst_n(rst_n), .clear(clear0), .in_valid(iv0), .in_ready(ir0),
      .in_product(prod0), .in_last(last0), .out_valid(ov0), .out_ready(ordy0),
      .out_sum(sum0), .out_count(cnt0), .out_ovf(ovf0));

   product_accumulator #(.N(4), .G(1), .CW(8)) d1 (
      .clk(clk), .rst_n(rst_n), .clear(clear1), .in_valid(iv1), .in_ready(ir1),
      .in_product(prod1), .in_last(last1), .out_valid(ov1), .out_ready(ordy1),
      .out_sum(sum1), .out_count(cnt1), .out_ovf(ovf1));

   int tests = 0;
   int fails = 0;

   typedef struct {
      int     d;
      int     n;
      longint b [6];
      longint esum;
      int     ecnt;
      bit     eovf;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input logic signed [127:0] a,
                      input logic signed [127:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, a, e);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int d, input bit v, input longint p, input bit l);
      if (d == 0) begin iv0 = v; prod0 = 64'(p); last0 = l; end
      else        begin iv1 = v; prod1 = 8'(p);  last1 = l; end
   endtask

   task automatic set_ordy(input int d, input bit r);
      if (d == 0) ordy0 = r; else ordy1 = r;
   endtask

   function automatic logic signed [127:0] osum(input int d);
      logic signed [127:0] r;
      if (d == 0) r = $signed(sum0); else r = $signed(sum1);
      return r;
   endfunction

   function automatic int ocnt(input int d);
      return (d == 0) ? int'(cnt0) : int'(cnt1);
   endfunction

   function automatic bit ovld(input int d);
      return (d == 0) ? ov0 : ov1;
   endfunction

   function automatic bit ordy_in(input int d);
      return (d == 0) ? ir0 : ir1;
   endfunction

   function automatic bit oovf(input int d);
      return (d == 0) ? ovf0 : ovf1;
   endfunction

   // Send one frame, check the held result, then complete the handshake
   task automatic run_frame(input string tag, input int d, input int n,
                            input longint b [6], input longint esum,
                            input int ecnt, input bit eovf);
      chk({tag, "_in_ready"}, ordy_in(d), 1);
      for (int i = 0; i < n; i++) begin
         drive(d, 1'b1, b[i], i == n-1);
         step;
      end
      drive(d, 1'b0, 0, 1'b0);
      chk({tag, "_valid"}, ovld(d), 1);
      chk({tag, "_sum"},   osum(d), esum);
      chk({tag, "_count"}, ocnt(d), ecnt);
      chk({tag, "_ovf"},   oovf(d), eovf);
      set_ordy(d, 1'b1);
      step;
      set_ordy(d, 1'b0);
      chk({tag, "_valid_drop"}, ovld(d), 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      longint acc;
      int     cnt, n, i, stall;
      bit     ov, v;
      longint p;

      vecs[0] = '{0, 3, '{3, -5, 10, 0, 0, 0}, 8, 3, 1'b0};
      vecs[1] = '{1, 6, '{49, 49, 49, 49, 49, 49}, 255, 6, 1'b1};
      vecs[2] = '{1, 5, '{-56, -56, -56, -56, -56, 0}, -256, 5, 1'b1};
      vecs[3] = '{0, 1, '{-64'sd1234567890123, 0, 0, 0, 0, 0}, -64'sd1234567890123, 1, 1'b0};
      vecs[4] = '{1, 5, '{127, 127, -128, -128, 5, 0}, 3, 5, 1'b0};
      vecs[5] = '{1, 4, '{127, 127, 127, -128, 0, 0}, 127, 4, 1'b1};
      vecs[6] = '{1, 3, '{127, 127, 1, 0, 0, 0}, 255, 3, 1'b0};
      vecs[7] = '{1, 2, '{-128, -128, 0, 0, 0, 0}, -256, 2, 1'b0};

      // reset state
      #3;
      chk("rst_in_ready", ir0, 0);
      chk("rst_valid", ov0, 0);
      chk("rst_sum", $signed(sum0), 0);
      chk("rst_count", cnt0, 0);
      chk("rst_ovf", ovf0, 0);
      chk("rst_in_ready_n", ir1, 0);
      #10 rst_n = 1'b1;
      step;
      chk("post_rst_in_ready", ir0, 1);

      // table-driven frames
      for (int k = 0; k < 8; k++)
         run_frame($sformatf("vec%0d", k), vecs[k].d, vecs[k].n, vecs[k].b,
                   vecs[k].esum, vecs[k].ecnt, vecs[k].eovf);

      // backpressure with the next frame's first beat waiting
      drive(0, 1'b1, 1, 1'b0); step;
      drive(0, 1'b1, 2, 1'b1); step;
      drive(0, 1'b1, 50, 1'b0);
      chk("bp_valid0", ov0, 1);
      chk("bp_sum0", $signed(sum0), 3);
      for (int s = 0; s < 5; s++) begin
         step;
         chk("bp_in_ready", ir0, 0);
         chk("bp_valid", ov0, 1);
         chk("bp_sum", $signed(sum0), 3);
         chk("bp_count", cnt0, 2);
      end
      ordy0 = 1'b1; step; ordy0 = 1'b0;
      chk("bp_release_valid", ov0, 0);
      chk("bp_release_ready", ir0, 1);
      step;                                  // beat 50 accepted here
      drive(0, 1'b1, 60, 1'b1); step;
      drive(0, 1'b0, 0, 1'b0);
      chk("bp_next_valid", ov0, 1);
      chk("bp_next_sum", $signed(sum0), 110);
      chk("bp_next_count", cnt0, 2);
      ordy0 = 1'b1; step; ordy0 = 1'b0;

      // clear mid-frame, with a beat in the same cycle
      drive(0, 1'b1, 7, 1'b0); step; step;
      clear0 = 1'b1; drive(0, 1'b1, 100, 1'b0); step;
      clear0 = 1'b0; drive(0, 1'b0, 0, 1'b0);
      chk("clr_in_ready", ir0, 1);
      chk("clr_valid", ov0, 0);
      run_frame("clr", 0, 2, '{1, 2, 0, 0, 0, 0}, 3, 2, 1'b0);

      // clear while holding a result
      drive(0, 1'b1, 5, 1'b1); step;
      drive(0, 1'b0, 0, 1'b0);
      chk("clrh_valid", ov0, 1);
      clear0 = 1'b1; step; clear0 = 1'b0;
      chk("clrh_valid_drop", ov0, 0);
      run_frame("clrh", 0, 1, '{4, 0, 0, 0, 0, 0}, 4, 1, 1'b0);

      // asynchronous reset during HOLD
      drive(0, 1'b1, 9, 1'b1); step;
      drive(0, 1'b0, 0, 1'b0);
      chk("rsth_valid", ov0, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rsth_valid_drop", ov0, 0);
      chk("rsth_in_ready", ir0, 0);
      chk("rsth_sum", $signed(sum0), 0);
      chk("rsth_count", cnt0, 0);
      #3 rst_n = 1'b1;
      step;
      run_frame("rsth", 0, 1, '{-1, 0, 0, 0, 0, 0}, -1, 1, 1'b0);

      // random frames on the narrow instance against a saturating model
      for (int f = 0; f < 12; f++) begin
         n = (f == 0) ? 300 : (f == 1) ? 256 : int'($urandom_range(1, 300));
         acc = 0; cnt = 0; ov = 1'b0; i = 0;
         while (i < n) begin
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) != 0) p = longint'(int'($urandom_range(0, 255)) - 128);
            else                          p = longint'(int'($urandom_range(0, 15)) - 8);
            drive(1, v, p, v && (i == n-1));
            step;
            if (v) begin
               acc = acc + p;
               if (acc > 255)       begin acc = 255;  ov = 1'b1; end
               else if (acc < -256) begin acc = -256; ov = 1'b1; end
               if (cnt < 255) cnt++;
               i++;
            end
         end
         drive(1, 1'b0, 0, 1'b0);
         chk($sformatf("rnd%0d_valid", f), ov1, 1);
         chk($sformatf("rnd%0d_sum", f), $signed(sum1), acc);
         chk($sformatf("rnd%0d_count", f), cnt1, cnt);
         chk($sformatf("rnd%0d_ovf", f), ovf1, ov);
         stall = int'($urandom_range(0, 4));
         for (int s = 0; s < stall; s++) begin
            drive(1, 1'b1, 17, 1'b0);
            step;
            chk($sformatf("rnd%0d_stall_valid", f), ov1, 1);
            chk($sformatf("rnd%0d_stall_sum", f), $signed(sum1), acc);
            chk($sformatf("rnd%0d_stall_ready", f), ir1, 0);
         end
         drive(1, 1'b0, 0, 1'b0);
         ordy1 = 1'b1; step; ordy1 = 1'b0;
         chk($sformatf("rnd%0d_valid_drop", f), ov1, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
